// File: rtl/capture_pkg.sv
// capture_pkg: shared definitions for the capture controller.
//   state_t    - FSM state encoding (codes 0..5 are visible on o_state)
//   EDGE_*     - trigger qualification modes for i_edge_mode
package capture_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StPre  = 3'd1,
        StWait = 3'd2,
        StPost = 3'd3,
        StDone = 3'd4,
        StRead = 3'd5
    } state_t;

    localparam logic [1:0] EDGE_RISE  = 2'd0;
    localparam logic [1:0] EDGE_FALL  = 2'd1;
    localparam logic [1:0] EDGE_BOTH  = 2'd2;
    localparam logic [1:0] LEVEL_HIGH = 2'd3;

endpackage

// File: rtl/trig_edge_det.sv
// trig_edge_det: turns the synchronised trigger line into a qualified trigger pulse.
// Ports:
//   clk          clock
//   i_rst        synchronous active-high reset (clears the history bit)
//   i_trig_in    raw trigger, already in the clk domain
//   i_edge_mode  EDGE_RISE / EDGE_FALL / EDGE_BOTH / LEVEL_HIGH
//   o_pulse      combinational trigger qualifier for the current cycle
module trig_edge_det
    import capture_pkg::*;
(
    input  logic       clk,
    input  logic       i_rst,
    input  logic       i_trig_in,
    input  logic [1:0] i_edge_mode,
    output logic       o_pulse
);

    logic prev_q;

    // History is sampled every cycle regardless of controller state so that
    // the first WAIT cycle compares against the true previous level.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= i_trig_in;
        end
    end

    always_comb begin
        o_pulse = 1'b0;
        unique case (i_edge_mode)
            EDGE_RISE:  o_pulse = i_trig_in & ~prev_q;
            EDGE_FALL:  o_pulse = ~i_trig_in & prev_q;
            EDGE_BOTH:  o_pulse = i_trig_in ^ prev_q;
            LEVEL_HIGH: o_pulse = i_trig_in;
        endcase
    end

endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: pre/post-trigger capture controller for a 2**ADDR_W sample BRAM.
// Arms on i_arm, fills a ring buffer with a pre-trigger window, waits for a trigger,
// writes the post-trigger window so the buffer holds exactly DEPTH samples, then
// reads the capture out oldest-first on i_rd_req.
// Optional build macro CAPTURE_TIMEOUT_EN adds an auto-trigger timeout
// (i_timeout, o_timed_out); i_timeout == 0 disables it.
// Ports:
//   clk, i_rst            clock, synchronous active-high reset
//   i_arm, i_abort        start capture (IDLE only) / return to IDLE (top priority)
//   i_trig_in             synchronised trigger line
//   i_edge_mode           trigger mode (see capture_pkg)
//   i_pre_len             pre-trigger sample count, latched at arm
//   i_rd_req              start readout (DONE only)
//   o_wr_en, o_wr_addr    BRAM write port control
//   o_rd_en, o_rd_addr    BRAM read port control
//   o_full                capture valid in BRAM
//   o_busy                not IDLE
//   o_trig_addr           address holding the trigger sample
//   o_state               current state code
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_arm,
    input  logic              i_abort,
    input  logic              i_trig_in,
    input  logic [1:0]        i_edge_mode,
    input  logic [ADDR_W-1:0] i_pre_len,
    input  logic              i_rd_req,
`ifdef CAPTURE_TIMEOUT_EN
    input  logic [TIMEOUT_W-1:0] i_timeout,
    output logic              o_timed_out,
`endif
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_full,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_trig_addr,
    output logic [2:0]        o_state
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    state_t            state_q;
    logic [ADDR_W-1:0] pre_len_q;
    logic [ADDR_W-1:0] post_rem_q;
    logic [ADDR_W-1:0] cnt_q;       // PRE write count, then READ count
    logic              trig_pulse;
    logic              to_hit;
    logic              fire;

    trig_edge_det u_edge_det (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_trig_in   (i_trig_in),
        .i_edge_mode (i_edge_mode),
        .o_pulse     (trig_pulse)
    );

`ifdef CAPTURE_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] to_cnt_q;
    logic                 timed_out_q;

    // to_cnt_q holds (WAIT cycles so far - 1); the forced trigger lands on the
    // i_timeout-th WAIT cycle.
    assign to_hit = (i_timeout != '0) && ((to_cnt_q + TIMEOUT_W'(1)) == i_timeout);
    assign o_timed_out = timed_out_q;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            to_cnt_q    <= '0;
            timed_out_q <= 1'b0;
        end else if (i_abort) begin
            to_cnt_q    <= '0;
            timed_out_q <= 1'b0;
        end else begin
            // Held at zero outside WAIT, so it is clear on every WAIT entry.
            if (state_q == StWait) begin
                to_cnt_q <= to_cnt_q + TIMEOUT_W'(1);
            end else begin
                to_cnt_q <= '0;
            end
            if (state_q == StIdle && i_arm) begin
                timed_out_q <= 1'b0;
            end else if (state_q == StWait && to_hit && !trig_pulse) begin
                timed_out_q <= 1'b1;
            end
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    assign fire    = trig_pulse | to_hit;
    assign o_busy  = (state_q != StIdle);
    assign o_state = state_q;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            pre_len_q   <= '0;
            post_rem_q  <= '0;
            cnt_q       <= '0;
            o_wr_en     <= 1'b0;
            o_wr_addr   <= '0;
            o_rd_en     <= 1'b0;
            o_rd_addr   <= '0;
            o_full      <= 1'b0;
            o_trig_addr <= '0;
        end else if (i_abort) begin
            state_q <= StIdle;
            o_wr_en <= 1'b0;
            o_rd_en <= 1'b0;
            o_full  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_arm) begin
                        pre_len_q  <= i_pre_len;
                        post_rem_q <= ~i_pre_len;  // DEPTH-1-pre_len
                        cnt_q      <= '0;
                        o_wr_addr  <= '0;
                        o_wr_en    <= 1'b1;
                        state_q    <= (i_pre_len != '0) ? StPre : StWait;
                    end
                end
                StPre: begin
                    o_wr_addr <= o_wr_addr + ADDR_W'(1);
                    cnt_q     <= cnt_q + ADDR_W'(1);
                    if (cnt_q == pre_len_q - ADDR_W'(1)) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    o_wr_addr <= o_wr_addr + ADDR_W'(1);
                    if (fire) begin
                        o_trig_addr <= o_wr_addr;
                        if (post_rem_q == '0) begin
                            state_q <= StDone;
                            o_wr_en <= 1'b0;
                            o_full  <= 1'b1;
                        end else begin
                            state_q <= StPost;
                        end
                    end
                end
                StPost: begin
                    o_wr_addr  <= o_wr_addr + ADDR_W'(1);
                    post_rem_q <= post_rem_q - ADDR_W'(1);
                    if (post_rem_q == ADDR_W'(1)) begin
                        state_q <= StDone;
                        o_wr_en <= 1'b0;
                        o_full  <= 1'b1;
                    end
                end
                StDone: begin
                    if (i_rd_req) begin
                        // Oldest sample sits pre_len slots before the trigger.
                        o_rd_addr <= o_trig_addr - pre_len_q;
                        cnt_q     <= '0;
                        o_rd_en   <= 1'b1;
                        state_q   <= StRead;
                    end
                end
                StRead: begin
                    o_rd_addr <= o_rd_addr + ADDR_W'(1);
                    cnt_q     <= cnt_q + ADDR_W'(1);
                    if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= StIdle;
                        o_rd_en <= 1'b0;
                        o_full  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    o_wr_en <= 1'b0;
                    o_rd_en <= 1'b0;
                    o_full  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed bench for capture_ctrl with ADDR_W=4 (DEPTH=16).
module tb_capture_ctrl;

    localparam int ADDR_W    = 4;
    localparam int TIMEOUT_W = 16;

    logic              clk = 1'b0;
    logic              i_rst;
    logic              i_arm;
    logic              i_abort;
    logic              i_trig_in;
    logic [1:0]        i_edge_mode;
    logic [ADDR_W-1:0] i_pre_len;
    logic              i_rd_req;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic              o_rd_en;
    logic [ADDR_W-1:0] o_rd_addr;
    logic              o_full;
    logic              o_busy;
    logic [ADDR_W-1:0] o_trig_addr;
    logic [2:0]        o_state;
`ifdef CAPTURE_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] i_timeout;
    logic                 o_timed_out;
`endif

    int checks   = 0;
    int failures = 0;

    capture_ctrl #(
        .ADDR_W    (ADDR_W),
        .TIMEOUT_W (TIMEOUT_W)
    ) dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_arm       (i_arm),
        .i_abort     (i_abort),
        .i_trig_in   (i_trig_in),
        .i_edge_mode (i_edge_mode),
        .i_pre_len   (i_pre_len),
        .i_rd_req    (i_rd_req),
`ifdef CAPTURE_TIMEOUT_EN
        .i_timeout   (i_timeout),
        .o_timed_out (o_timed_out),
`endif
        .o_wr_en     (o_wr_en),
        .o_wr_addr   (o_wr_addr),
        .o_rd_en     (o_rd_en),
        .o_rd_addr   (o_rd_addr),
        .o_full      (o_full),
        .o_busy      (o_busy),
        .o_trig_addr (o_trig_addr),
        .o_state     (o_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic       t0;    // trigger level during the arm cycle
        logic       t1;    // trigger level in the first WAIT cycle
        logic       fire;  // expected to leave WAIT
    } edge_vec_t;

    edge_vec_t vecs[13];

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int n;
        int last;

        vecs[0]  = '{2'd0, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{2'd0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{2'd0, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{2'd0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{2'd1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{2'd1, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{2'd2, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{2'd2, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{2'd2, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{2'd3, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{2'd3, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{2'd3, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{2'd3, 1'b0, 1'b0, 1'b0};

        i_rst = 1'b1; i_arm = 1'b0; i_abort = 1'b0; i_trig_in = 1'b0;
        i_edge_mode = 2'd0; i_pre_len = '0; i_rd_req = 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
        i_timeout = '0;
`endif
        cycle();
        cycle();
        check("rst_state", int'(o_state), 0);
        check("rst_wr_en", int'(o_wr_en), 0);
        check("rst_wr_addr", int'(o_wr_addr), 0);
        check("rst_rd_en", int'(o_rd_en), 0);
        check("rst_rd_addr", int'(o_rd_addr), 0);
        check("rst_full", int'(o_full), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_trig_addr", int'(o_trig_addr), 0);
        i_rst = 1'b0;

        // Read request while idle is ignored.
        i_rd_req = 1'b1; cycle(); i_rd_req = 1'b0;
        check("rdreq_idle_state", int'(o_state), 0);
        check("rdreq_idle_rd_en", int'(o_rd_en), 0);

        // Capture with pre_len=4, trigger at address 9, full readout.
        i_pre_len = 4; i_edge_mode = 2'd0; i_trig_in = 1'b0;
        i_arm = 1'b1; cycle(); i_arm = 1'b0;
        i_pre_len = 7;  // must not affect the running capture
        check("a_pre_state", int'(o_state), 1);
        check("a_pre_wr_en", int'(o_wr_en), 1);
        check("a_pre_wr_addr", int'(o_wr_addr), 0);
        check("a_pre_busy", int'(o_busy), 1);
        n = 0;
        while (o_state == 3'd1 && n < 40) begin n++; cycle(); end
        check("a_pre_cycles", n, 4);
        check("a_wait_state", int'(o_state), 2);
        check("a_wait_addr", int'(o_wr_addr), 4);
        repeat (5) cycle();
        check("a_wait_addr9", int'(o_wr_addr), 9);
        i_trig_in = 1'b1; cycle();
        check("a_post_state", int'(o_state), 3);
        check("a_trig_addr", int'(o_trig_addr), 9);
        check("a_post_addr", int'(o_wr_addr), 10);
        n = 0;
        while (o_state == 3'd3 && n < 40) begin n++; cycle(); end
        check("a_post_writes", n, 11);
        check("a_done_state", int'(o_state), 4);
        check("a_done_full", int'(o_full), 1);
        check("a_done_wr_en", int'(o_wr_en), 0);
        i_arm = 1'b1; cycle(); i_arm = 1'b0;
        check("a_arm_in_done", int'(o_state), 4);
        i_rd_req = 1'b1; cycle(); i_rd_req = 1'b0;
        check("a_read_state", int'(o_state), 5);
        check("a_read_rd_en", int'(o_rd_en), 1);
        check("a_read_start", int'(o_rd_addr), 5);
        check("a_read_full", int'(o_full), 1);
        n = 0; last = 0;
        while (o_rd_en && n < 40) begin n++; last = int'(o_rd_addr); cycle(); end
        check("a_read_cycles", n, 16);
        check("a_read_last", last, 4);
        check("a_end_state", int'(o_state), 0);
        check("a_end_full", int'(o_full), 0);
        check("a_end_busy", int'(o_busy), 0);
        i_trig_in = 1'b0;

        // pre_len=0: straight to WAIT, trigger at address 0, 15 POST writes.
        i_pre_len = 0; cycle();
        i_arm = 1'b1; cycle(); i_arm = 1'b0;
        check("b_wait_state", int'(o_state), 2);
        check("b_wait_addr", int'(o_wr_addr), 0);
        i_trig_in = 1'b1; cycle();
        check("b_post_state", int'(o_state), 3);
        check("b_trig_addr", int'(o_trig_addr), 0);
        n = 0;
        while (o_state == 3'd3 && n < 40) begin n++; cycle(); end
        check("b_post_writes", n, 15);
        check("b_done_state", int'(o_state), 4);
        i_trig_in = 1'b0;
        i_abort = 1'b1; cycle(); i_abort = 1'b0;
        check("b_abort_state", int'(o_state), 0);
        check("b_abort_full", int'(o_full), 0);

        // Abort during POST.
        i_arm = 1'b1; cycle(); i_arm = 1'b0;
        i_trig_in = 1'b1; cycle(); i_trig_in = 1'b0;
        cycle(); cycle();
        check("p_in_post", int'(o_state), 3);
        i_abort = 1'b1; cycle(); i_abort = 1'b0;
        check("p_abort_state", int'(o_state), 0);
        check("p_abort_wr_en", int'(o_wr_en), 0);
        check("p_abort_full", int'(o_full), 0);
        check("p_abort_busy", int'(o_busy), 0);

        // pre_len=15: edges during PRE ignored, WAIT -> DONE with no POST.
        i_pre_len = 15; i_edge_mode = 2'd0; i_trig_in = 1'b0;
        i_arm = 1'b1; cycle(); i_arm = 1'b0;
        n = 0;
        while (o_state == 3'd1 && n < 40) begin
            i_trig_in = n[0];
            n++;
            cycle();
        end
        check("c_pre_cycles", n, 15);
        check("c_wait_state", int'(o_state), 2);
        check("c_wait_addr", int'(o_wr_addr), 15);
        i_trig_in = 1'b0; cycle();
        check("c_wait_wrap", int'(o_wr_addr), 0);
        i_trig_in = 1'b1; cycle(); i_trig_in = 1'b0;
        check("c_done_state", int'(o_state), 4);
        check("c_trig_addr", int'(o_trig_addr), 0);
        check("c_done_full", int'(o_full), 1);
        check("c_done_wr_en", int'(o_wr_en), 0);
        i_rd_req = 1'b1; cycle(); i_rd_req = 1'b0;
        check("c_read_start", int'(o_rd_addr), 1);
        cycle(); cycle();
        check("c_read_addr", int'(o_rd_addr), 3);
        i_abort = 1'b1; cycle(); i_abort = 1'b0;
        check("c_abort_state", int'(o_state), 0);
        check("c_abort_rd_en", int'(o_rd_en), 0);
        check("c_abort_full", int'(o_full), 0);

        // Reset while in WAIT.
        i_pre_len = 0;
        i_arm = 1'b1; cycle(); i_arm = 1'b0;
        cycle(); cycle();
        check("r_wait_addr", int'(o_wr_addr), 2);
        i_rst = 1'b1; cycle(); i_rst = 1'b0;
        check("r_state", int'(o_state), 0);
        check("r_wr_en", int'(o_wr_en), 0);
        check("r_wr_addr", int'(o_wr_addr), 0);
        check("r_full", int'(o_full), 0);
        check("r_busy", int'(o_busy), 0);

        // Edge-mode table: arm with level t0, present t1 in the first WAIT cycle.
        for (int i = 0; i < 13; i++) begin
            i_abort = 1'b1; cycle(); i_abort = 1'b0;
            i_edge_mode = vecs[i].mode;
            i_pre_len = 0;
            i_trig_in = vecs[i].t0;
            i_arm = 1'b1; cycle(); i_arm = 1'b0;
            check($sformatf("edge%0d_arm", i), int'(o_state), 2);
            i_trig_in = vecs[i].t1;
            cycle();
            check($sformatf("edge%0d_fire", i), int'(o_state), vecs[i].fire ? 3 : 2);
        end
        i_abort = 1'b1; cycle(); i_abort = 1'b0;
        i_trig_in = 1'b0; i_edge_mode = 2'd0;

`ifdef CAPTURE_TIMEOUT_EN
        // Forced trigger on the 20th WAIT cycle (wr_addr 19 mod 16 = 3).
        i_timeout = 20; i_pre_len = 0;
        i_arm = 1'b1; cycle(); i_arm = 1'b0;
        n = 0;
        while (o_state == 3'd2 && n < 60) begin n++; cycle(); end
        check("t_wait_cycles", n, 20);
        check("t_post_state", int'(o_state), 3);
        check("t_timed_out", int'(o_timed_out), 1);
        check("t_trig_addr", int'(o_trig_addr), 3);
        n = 0;
        while (o_state == 3'd3 && n < 40) begin n++; cycle(); end
        i_rd_req = 1'b1; cycle(); i_rd_req = 1'b0;
        n = 0;
        while (o_rd_en && n < 40) begin n++; cycle(); end
        check("t_idle_state", int'(o_state), 0);
        check("t_held", int'(o_timed_out), 1);
        i_timeout = 0;
        i_arm = 1'b1; cycle(); i_arm = 1'b0;
        check("t_rearm_clear", int'(o_timed_out), 0);
        i_abort = 1'b1; cycle(); i_abort = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
